// File: rtl/vga_sync_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_sync_gen                                                    |
// | Brief    : VGA timing generator gated by a synchronised PLL-lock signal.  |
// |            Define VGA_SYNC_FRAME_CNT_EN to add the frame_cnt output.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 24,
    parameter int H_SYNC    = 40,
    parameter int H_BACK    = 128,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 9,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 28
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pll_locked,
    output logic        hsync,
    output logic        vsync,
    output logic        blankN,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        line_start,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        frame_start
);

    localparam logic [0:0]  c_ST_WAIT_LOCK = 1'b0;
    localparam logic [0:0]  c_ST_RUN       = 1'b1;

    localparam logic [10:0] c_H_LAST   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] c_V_LAST   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] c_H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] c_V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] c_HS_FIRST = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] c_HS_LAST  = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] c_VS_FIRST = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] c_VS_LAST  = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic        r_sync_meta;
    logic        r_lock_s;
    logic [0:0]  r_state;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank_n;
    logic        r_line_start;
    logic        r_frame_start;

    logic [0:0]  w_state_next;
    logic        w_run_next;
    logic [10:0] w_h_next;
    logic [10:0] w_v_next;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic        w_blank_n_next;
    logic        w_line_start_next;
    logic        w_frame_start_next;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_lock_s    <= r_sync_meta;
        end
    end

    // Every output is computed from the next counter pair so all of them
    // land in the same register stage and stay mutually aligned.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_WAIT_LOCK: if (r_lock_s)  w_state_next = c_ST_RUN;
            default:        if (!r_lock_s) w_state_next = c_ST_WAIT_LOCK;
        endcase
        w_run_next = (w_state_next == c_ST_RUN);

        w_h_next = '0;
        w_v_next = '0;
        if (w_run_next && (r_state == c_ST_RUN)) begin
            if (r_h_cnt == c_H_LAST) begin
                w_h_next = '0;
                w_v_next = (r_v_cnt == c_V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
            end else begin
                w_h_next = r_h_cnt + 11'd1;
                w_v_next = r_v_cnt;
            end
        end

        w_hsync_next       = ~(w_run_next && (w_h_next >= c_HS_FIRST) && (w_h_next <= c_HS_LAST));
        w_vsync_next       = ~(w_run_next && (w_v_next >= c_VS_FIRST) && (w_v_next <= c_VS_LAST));
        w_blank_n_next     = w_run_next && (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
        w_line_start_next  = w_run_next && (w_h_next == 11'd0);
        w_frame_start_next = w_line_start_next && (w_v_next == 11'd0);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= c_ST_WAIT_LOCK;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_blank_n     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_blank_n     <= w_blank_n_next;
            r_line_start  <= w_line_start_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blankN      = r_blank_n;
    assign pixel_x     = r_h_cnt;
    assign pixel_y     = r_v_cnt;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] w_frame_cnt_next;

    // The frame_start that opens a run comes from WAIT_LOCK and is not counted.
    always_comb begin
        w_frame_cnt_next = r_frame_cnt;
        if (!w_run_next) begin
            w_frame_cnt_next = '0;
        end else if (w_frame_start_next && (r_state == c_ST_RUN)) begin
            w_frame_cnt_next = r_frame_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= w_frame_cnt_next;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule
`default_nettype wire
